// File: rtl/dma_bus_arbiter.sv
// -----------------------------------------------------------------------------
// dma_bus_arbiter
//
// Owns the shared data-memory port between the CPU and the DMA engine. Runs
// the BR/BG handshake with the DMA and waits for any in-flight CPU data access
// to retire before granting. It steers address and strobes onto the memory
// data port and stalls the CPU data stage while the DMA owns the bus. The
// instruction port is not touched by this block.
//
// Optional feature macro: DMA_ARB_STEAL_EN
//   When it is defined, the CPU can steal single cycles out of a DMA grant.
//   A steal happens after a DMA write pulse that coincides with a CPU request,
//   or after HOLD_MAX consecutive granted cycles. When it is undefined, a
//   grant lasts until BR falls, and neither the STEAL path nor the hold
//   counter is built.
//
// Ports
//   clk            in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   BR             in   bus request from DMA
//   BG             out  bus grant to DMA (registered)
//   cpu_d_readM    in   CPU data read strobe
//   cpu_d_writeM   in   CPU data write strobe
//   cpu_d_address  in   CPU data address
//   cpu_mem_busy   in   CPU data access in flight, must not be split
//   dma_WRITE      in   DMA write strobe (one cycle per 4-word burst)
//   dma_addr       in   DMA burst base address
//   dma_offset     in   DMA burst index (not needed for steering)
//   mem_d_readM    out  memory data-port read strobe
//   mem_d_writeM   out  memory data-port write strobe
//   mem_d_address  out  memory data-port address
//   cpu_stall      out  freeze CPU data stage
//   grant_cycles   out  saturating count of cycles with BG=1 since reset
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | CPU owns the data port
// DRAIN   | DMA requested; waiting for the CPU access in flight to retire
// GRANT   | DMA owns the data port, BG=1
// STEAL   | one-cycle CPU slot inside a grant (DMA_ARB_STEAL_EN only)
// RELEASE | one turnaround cycle with the port idle after BR falls
// -----------------------------------------------------------------------------
module dma_bus_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int HOLD_MAX  = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 BR,
    output logic                 BG,
    input  logic                 cpu_d_readM,
    input  logic                 cpu_d_writeM,
    input  logic [WORD_SIZE-1:0] cpu_d_address,
    input  logic                 cpu_mem_busy,
    input  logic                 dma_WRITE,
    input  logic [WORD_SIZE-1:0] dma_addr,
    input  logic [1:0]           dma_offset,
    output logic                 mem_d_readM,
    output logic                 mem_d_writeM,
    output logic [WORD_SIZE-1:0] mem_d_address,
    output logic                 cpu_stall,
    output logic [15:0]          grant_cycles
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRAIN   = 3'd1,
        S_GRANT   = 3'd2,
        S_STEAL   = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        bg_q;
    logic [15:0] grant_q;
    logic        cpu_req;

    assign cpu_req = cpu_d_readM | cpu_d_writeM;

    // The burst index only matters to the DMA itself; the memory sees dma_addr.
    logic unused_offset;
    assign unused_offset = ^dma_offset;

`ifdef DMA_ARB_STEAL_EN
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);
    logic [15:0] hold_q;
`else
    logic unused_hold;
    assign unused_hold = (HOLD_MAX > 0);
`endif

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (BR) state_d = cpu_mem_busy ? S_DRAIN : S_GRANT;
            end
            S_DRAIN: begin
                if (!BR)               state_d = S_IDLE;
                else if (!cpu_mem_busy) state_d = S_GRANT;
            end
            S_GRANT: begin
                // BR falling wins over a steal; a write in this cycle is still driven.
                if (!BR) begin
                    state_d = S_RELEASE;
                end
`ifdef DMA_ARB_STEAL_EN
                else if ((dma_WRITE && cpu_req) || (hold_q == HOLD_LAST)) begin
                    state_d = S_STEAL;
                end
`endif
            end
            S_STEAL:   state_d = BR ? S_GRANT : S_IDLE;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            bg_q    <= 1'b0;
            grant_q <= 16'd0;
`ifdef DMA_ARB_STEAL_EN
            hold_q  <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            bg_q    <= (state_d == S_GRANT);
            if (bg_q && (grant_q != 16'hFFFF)) begin
                grant_q <= grant_q + 16'd1;
            end
`ifdef DMA_ARB_STEAL_EN
            // hold_q counts granted cycles already completed in the current run
            if ((state_q == S_GRANT) && (state_d == S_GRANT)) begin
                hold_q <= hold_q + 16'd1;
            end else begin
                hold_q <= 16'd0;
            end
`endif
        end
    end

    assign BG           = bg_q;
    assign grant_cycles = grant_q;

    // ------------------------------------------------------------ port steering
    always_comb begin
        mem_d_readM   = cpu_d_readM;
        mem_d_writeM  = cpu_d_writeM;
        mem_d_address = cpu_d_address;
        cpu_stall     = 1'b0;
        case (state_q)
            S_IDLE, S_DRAIN: begin
                // A fresh CPU request racing a grantable BR loses and must be retried.
                cpu_stall = BR & ~cpu_mem_busy & cpu_req;
            end
            S_GRANT: begin
                mem_d_readM   = 1'b0;
                mem_d_writeM  = dma_WRITE;
                mem_d_address = dma_addr;
                cpu_stall     = cpu_req;
            end
            S_STEAL: begin
                cpu_stall = 1'b0;
            end
            S_RELEASE: begin
                mem_d_readM   = 1'b0;
                mem_d_writeM  = 1'b0;
                mem_d_address = '0;
                // A stalled CPU keeps its request up, so this holds the stall.
                cpu_stall     = cpu_req;
            end
            default: begin
                cpu_stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
module tb_dma_bus_arbiter;

    logic        clk;
    logic        reset_n;
    logic        BR;
    logic        BG;
    logic        cpu_d_readM;
    logic        cpu_d_writeM;
    logic [15:0] cpu_d_address;
    logic        cpu_mem_busy;
    logic        dma_WRITE;
    logic [15:0] dma_addr;
    logic [1:0]  dma_offset;
    logic        mem_d_readM;
    logic        mem_d_writeM;
    logic [15:0] mem_d_address;
    logic        cpu_stall;
    logic [15:0] grant_cycles;

    int total = 0;
    int bad   = 0;
    int exp_grant = 0;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
    } acc_t;
    acc_t exp_q[$];

    dma_bus_arbiter #(.WORD_SIZE(16), .HOLD_MAX(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .BR           (BR),
        .BG           (BG),
        .cpu_d_readM  (cpu_d_readM),
        .cpu_d_writeM (cpu_d_writeM),
        .cpu_d_address(cpu_d_address),
        .cpu_mem_busy (cpu_mem_busy),
        .dma_WRITE    (dma_WRITE),
        .dma_addr     (dma_addr),
        .dma_offset   (dma_offset),
        .mem_d_readM  (mem_d_readM),
        .mem_d_writeM (mem_d_writeM),
        .mem_d_address(mem_d_address),
        .cpu_stall    (cpu_stall),
        .grant_cycles (grant_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; BR = 1'b1;
        cpu_d_readM = 1'b0; cpu_d_writeM = 1'b0; cpu_d_address = 16'h1234;
        cpu_mem_busy = 1'b0; dma_WRITE = 1'b0; dma_addr = 16'h0; dma_offset = 2'd0;
        repeat (3) tick();
        total++; if (BG !== 1'b0) begin bad++; $display("FAIL reset_bg got=%0b want=0", BG); end
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", cpu_stall); end
        total++; if (grant_cycles !== 16'd0) begin bad++; $display("FAIL reset_grant got=%0d want=0", grant_cycles); end
        total++; if (mem_d_address !== 16'h1234) begin bad++; $display("FAIL reset_mem_addr got=%h want=1234", mem_d_address); end
        reset_n = 1'b1;
        #1;
        total++; if (BG !== 1'b0) begin bad++; $display("FAIL reset_release_bg got=%0b want=0", BG); end
        tick();
        total++; if (BG !== 1'b1) begin bad++; $display("FAIL reset_first_grant got=%0b want=1", BG); end
        tick();
        total++; if (grant_cycles !== 16'd1) begin bad++; $display("FAIL reset_grant_count got=%0d want=1", grant_cycles); end
        BR = 1'b0;
        tick();
        total++; if (BG !== 1'b0) begin bad++; $display("FAIL reset_bg_fall got=%0b want=0", BG); end
        tick();
        exp_grant = 2;
        total++; if (grant_cycles !== 16'(exp_grant)) begin bad++; $display("FAIL reset_grant_total got=%0d want=%0d", grant_cycles, exp_grant); end
    endtask

    task automatic test_async_reset_mid_grant();
        BR = 1'b1;
        tick();
        total++; if (BG !== 1'b1) begin bad++; $display("FAIL midrst_pre_bg got=%0b want=1", BG); end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (BG !== 1'b0) begin bad++; $display("FAIL midrst_bg_async got=%0b want=0", BG); end
        total++; if (grant_cycles !== 16'd0) begin bad++; $display("FAIL midrst_grant got=%0d want=0", grant_cycles); end
        BR = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        total++; if (BG !== 1'b0) begin bad++; $display("FAIL midrst_post_bg got=%0b want=0", BG); end
        exp_grant = 0;
    endtask

    task automatic test_drain();
        BR = 1'b1; cpu_mem_busy = 1'b1; cpu_d_address = 16'h0ABC;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (BG !== 1'b0) begin bad++; $display("FAIL drain_bg_low c=%0d got=%0b want=0", c, BG); end
            total++; if (mem_d_address !== 16'h0ABC) begin bad++; $display("FAIL drain_cpu_mux c=%0d got=%h want=0abc", c, mem_d_address); end
            tick();
        end
        total++; if (BG !== 1'b0) begin bad++; $display("FAIL drain_bg_last got=%0b want=0", BG); end
        cpu_mem_busy = 1'b0;
        tick();
        total++; if (BG !== 1'b1) begin bad++; $display("FAIL drain_bg_rise got=%0b want=1", BG); end
        BR = 1'b0;
        tick();
        tick();
        exp_grant += 1;
        total++; if (grant_cycles !== 16'(exp_grant)) begin bad++; $display("FAIL drain_grant got=%0d want=%0d", grant_cycles, exp_grant); end
    endtask

    task automatic test_full_transfer();
        logic [15:0] addrs [3];
        acc_t e;
        int writes;
        addrs[0] = 16'h01F4; addrs[1] = 16'h01F8; addrs[2] = 16'h01FC;
        writes = 0;
        BR = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            dma_WRITE  = (c % 2 == 0);
            dma_addr   = addrs[c / 2];
            dma_offset = 2'(c / 2);
            if (c == 4) BR = 1'b0;
            if (dma_WRITE) exp_q.push_back('{1'b1, addrs[c / 2]});
            #1;
            total++; if (BG !== 1'b1) begin bad++; $display("FAIL xfer_bg c=%0d got=%0b want=1", c, BG); end
            if (mem_d_writeM === 1'b1) begin
                writes++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL xfer_unexpected_write addr=%h want=none", mem_d_address);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_d_address !== e.addr || e.wr !== 1'b1) begin
                        bad++; $display("FAIL xfer_write_addr got=%h want=%h", mem_d_address, e.addr);
                    end
                end
            end
            tick();
        end
        dma_WRITE = 1'b0;
        #1;
        exp_grant += 5;
        total++; if (BG !== 1'b0) begin bad++; $display("FAIL xfer_bg_fall got=%0b want=0", BG); end
        total++; if (mem_d_writeM !== 1'b0) begin bad++; $display("FAIL xfer_release_write got=%0b want=0", mem_d_writeM); end
        total++; if (grant_cycles !== 16'(exp_grant)) begin bad++; $display("FAIL xfer_grant got=%0d want=%0d", grant_cycles, exp_grant); end
        tick();
        total++; if (writes !== 3) begin bad++; $display("FAIL xfer_write_count got=%0d want=3", writes); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL xfer_queue_left got=%0d want=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_cpu_contention();
        acc_t e;
        BR = 1'b1; dma_addr = 16'h0200;
        tick();
        cpu_d_readM = 1'b1; cpu_d_address = 16'h0040;
        exp_q.push_back('{1'b0, 16'h0040});
        #1;
        total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL cont_stall_grant got=%0b want=1", cpu_stall); end
        total++; if (mem_d_readM !== 1'b0) begin bad++; $display("FAIL cont_no_cpu_read got=%0b want=0", mem_d_readM); end
        total++; if (mem_d_address !== 16'h0200) begin bad++; $display("FAIL cont_dma_addr got=%h want=0200", mem_d_address); end
        tick();
        BR = 1'b0;
        tick();
        total++; if (BG !== 1'b0) begin bad++; $display("FAIL cont_release_bg got=%0b want=0", BG); end
        total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL cont_stall_release got=%0b want=1", cpu_stall); end
        total++; if (mem_d_readM !== 1'b0) begin bad++; $display("FAIL cont_release_read got=%0b want=0", mem_d_readM); end
        tick();
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL cont_stall_idle got=%0b want=0", cpu_stall); end
        total++;
        if (mem_d_readM !== 1'b1) begin
            bad++; $display("FAIL cont_read_reaches got=%0b want=1", mem_d_readM);
        end else if (exp_q.size() == 0) begin
            bad++; $display("FAIL cont_read_unexpected addr=%h want=none", mem_d_address);
        end else begin
            e = exp_q.pop_front();
            if (mem_d_address !== e.addr || e.wr !== 1'b0) begin
                bad++; $display("FAIL cont_read_addr got=%h want=%h", mem_d_address, e.addr);
            end
        end
        cpu_d_readM = 1'b0;
        exp_grant += 2;
        total++; if (grant_cycles !== 16'(exp_grant)) begin bad++; $display("FAIL cont_grant got=%0d want=%0d", grant_cycles, exp_grant); end
        exp_q.delete();
    endtask

    task automatic test_simultaneous();
        BR = 1'b1; cpu_d_writeM = 1'b1; cpu_d_address = 16'h0077;
        #1;
        total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL simul_dma_wins got=%0b want=1", cpu_stall); end
        tick();
        total++; if (BG !== 1'b1) begin bad++; $display("FAIL simul_bg got=%0b want=1", BG); end
        total++; if (mem_d_writeM !== 1'b0) begin bad++; $display("FAIL simul_no_cpu_write got=%0b want=0", mem_d_writeM); end
        BR = 1'b0;
        tick();
        tick();
        total++; if (mem_d_writeM !== 1'b1 || mem_d_address !== 16'h0077) begin
            bad++; $display("FAIL simul_cpu_retry got=%0b/%h want=1/0077", mem_d_writeM, mem_d_address);
        end
        cpu_d_writeM = 1'b0;
        exp_grant += 1;
    endtask

    task automatic test_steal();
        logic exp_bg;
        BR = 1'b1; cpu_d_readM = 1'b1; cpu_d_address = 16'h0040; dma_WRITE = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            tick();
`ifdef DMA_ARB_STEAL_EN
            exp_bg = (k % 9 != 0);
`else
            exp_bg = 1'b1;
`endif
            total++; if (BG !== exp_bg) begin bad++; $display("FAIL steal_bg k=%0d got=%0b want=%0b", k, BG, exp_bg); end
            total++; if (cpu_stall !== exp_bg) begin bad++; $display("FAIL steal_stall k=%0d got=%0b want=%0b", k, cpu_stall, exp_bg); end
            total++; if (mem_d_readM !== !exp_bg) begin bad++; $display("FAIL steal_read k=%0d got=%0b want=%0b", k, mem_d_readM, !exp_bg); end
        end
        BR = 1'b0;
        tick();
        cpu_d_readM = 1'b0;
        tick();
`ifdef DMA_ARB_STEAL_EN
        exp_grant += 24;
`else
        exp_grant += 26;
`endif
        total++; if (grant_cycles !== 16'(exp_grant)) begin bad++; $display("FAIL steal_grant got=%0d want=%0d", grant_cycles, exp_grant); end
    endtask

    initial begin
        test_reset();
        test_async_reset_mid_grant();
        test_drain();
        test_full_transfer();
        test_cpu_contention();
        test_simultaneous();
        test_steal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
